// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-segment scan decoder: debounces each scanned digit, decodes it into a
// shadow frame, and hands complete 4-digit frames to a valid/ready consumer.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] out_value,
    output logic [3:0]  out_bad,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun
);
    localparam logic [7:0] SC = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {SETTLE, CAPTURE, HOLD} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [3:0]  prev_an;
    logic [6:0]  prev_seg;
    logic [3:0]  seen;
    logic [15:0] shadow_val;
    logic [3:0]  shadow_bad;
    logic        same, qual, cap;
    logic [3:0]  dec_nib;
    logic        dec_bad;

    assign same = (an_in == prev_an) && (seg_in == prev_seg);

    always_comb begin
        qual = 1'b0;
        case (an_in)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: qual = 1'b1;
            default: qual = 1'b0;
        endcase
    end

    // Active-low segment patterns; anything off-table decodes to 0 with bad set
    always_comb begin
        dec_bad = 1'b0;
        dec_nib = 4'h0;
        case (seg_in)
            7'h40: dec_nib = 4'h0;
            7'h79: dec_nib = 4'h1;
            7'h24: dec_nib = 4'h2;
            7'h30: dec_nib = 4'h3;
            7'h19: dec_nib = 4'h4;
            7'h12: dec_nib = 4'h5;
            7'h02: dec_nib = 4'h6;
            7'h78: dec_nib = 4'h7;
            7'h00: dec_nib = 4'h8;
            7'h10: dec_nib = 4'h9;
            7'h08: dec_nib = 4'hA;
            7'h03: dec_nib = 4'hB;
            7'h46: dec_nib = 4'hC;
            7'h21: dec_nib = 4'hD;
            7'h06: dec_nib = 4'hE;
            7'h0E: dec_nib = 4'hF;
            default: dec_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap       = 1'b0;
        case (state)
            SETTLE: begin
                if (same && qual) begin
                    // Jump on the edge the count would reach SC so the seen bit
                    // lands STABLE_CYCLES+1 cycles after the digit first appears
                    if (cnt + 8'd1 == SC) begin
                        state_nxt = CAPTURE;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end else begin
                    cnt_nxt = 8'd0;
                end
            end
            CAPTURE: begin
                cap       = qual;
                state_nxt = HOLD;
            end
            HOLD: begin
                cnt_nxt = 8'd0;
                if (!same) state_nxt = SETTLE;
            end
            default: begin
                state_nxt = SETTLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SETTLE;
            cnt        <= 8'd0;
            prev_an    <= 4'h0;
            prev_seg   <= 7'h0;
            seen       <= 4'h0;
            shadow_val <= 16'h0;
            shadow_bad <= 4'h0;
            out_value  <= 16'h0;
            out_bad    <= 4'h0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            prev_an  <= an_in;
            prev_seg <= seg_in;

            if (seen == 4'hF) begin
                if (!out_valid || out_ready) begin
                    out_value <= shadow_val;
                    out_bad   <= shadow_bad;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            seen <= ((seen == 4'hF) ? 4'h0 : seen) | (cap ? ~an_in : 4'h0);

            if (cap) begin
                for (int i = 0; i < 4; i++) begin
                    if (!an_in[i]) begin
                        shadow_val[i*4 +: 4] <= dec_nib;
                        shadow_bad[i]        <= dec_bad;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomized + directed bench for seg7_scan_decoder against a run-length reference model.
module tb_seg7_scan_decoder;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = 7'h7F;
    logic [3:0]  an_in = 4'hF;
    logic [15:0] out_value;
    logic [3:0]  out_bad;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        overrun;

    seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
        .out_value(out_value), .out_bad(out_bad), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_chk = 0, n_pass = 0;
    int rdy_mode = 0;  // 0 hold, 1 random, 2 accept exactly on frame completion

    // reference model state
    logic [15:0] m_val, m_sh_val;
    logic [3:0]  m_bad, m_sh_bad, m_seen, m_last_an;
    logic [6:0]  m_last_seg;
    logic        m_valid, m_ovr, m_pend, m_done;
    int          m_run;

    logic        got_frame;
    logic [15:0] got_val;
    logic [3:0]  got_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit one_low(input logic [3:0] an);
        return $countones(~an) == 1;
    endfunction

    task automatic model_reset();
        m_val = 0; m_sh_val = 0; m_bad = 0; m_sh_bad = 0; m_seen = 0;
        m_last_an = 0; m_last_seg = 0; m_valid = 0; m_ovr = 0;
        m_pend = 0; m_done = 0; m_run = 0;
    endtask

    task automatic model_step();
        if (rst) begin model_reset(); return; end
        if (m_seen == 4'hF) begin
            if (!m_valid || out_ready) begin
                m_val = m_sh_val; m_bad = m_sh_bad; m_valid = 1;
            end else m_ovr = 1;
            m_seen = 0;
        end else if (m_valid && out_ready) m_valid = 0;
        if (m_pend && one_low(an_in)) begin
            int idx = 0;
            logic [3:0] nib = 0;
            logic bad = 1;
            for (int i = 0; i < 4; i++) if (!an_in[i]) idx = i;
            for (int k = 0; k < 16; k++) if (seg_tab[k] == seg_in) begin nib = 4'(k); bad = 0; end
            m_sh_val[idx*4 +: 4] = nib;
            m_sh_bad[idx] = bad;
            m_seen[idx] = 1;
        end
        m_pend = 0;
        // a digit is taken once per unchanged stretch, after S repeats of its first sample
        if (an_in != m_last_an || seg_in != m_last_seg) begin m_run = 0; m_done = 0; end
        else if (one_low(an_in)) m_run++;
        else m_run = 0;
        if (!m_done && m_run == S) begin m_pend = 1; m_done = 1; end
        m_last_an = an_in; m_last_seg = seg_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("value", 32'(out_value), 32'(m_val));
        chk("bad", 32'(out_bad), 32'(m_bad));
        chk("valid", 32'(out_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (out_valid) begin got_frame = 1; got_val = out_value; got_bad = out_bad; end
    endtask

    task automatic show(input logic [3:0] an, input logic [6:0] seg, input int hold);
        for (int c = 0; c < hold; c++) begin
            an_in = an; seg_in = seg;
            if (rdy_mode == 1) out_ready = ($urandom % 4) != 0;
            else if (rdy_mode == 2) out_ready = (m_seen == 4'hF);
            tick();
        end
    endtask

    task automatic show_frame(input logic [15:0] v, input int hold);
        for (int d = 3; d >= 0; d--) show(~(4'b0001 << d), seg_tab[v[d*4 +: 4]], hold);
    endtask

    task automatic do_reset();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    initial begin
        logic [3:0] an;
        logic [6:0] seg;
        int hold;
        model_reset();
        got_frame = 0; got_val = 0; got_bad = 0;
        do_reset();
        chk("rst_value", 32'(out_value), 0);
        chk("rst_valid", 32'(out_valid), 0);

        // clean scan of 12AF
        got_frame = 0;
        show_frame(16'h12AF, 8);
        show(4'hF, 7'h7F, 3);
        chk("f12af_seen", 32'(got_frame), 1);
        chk("f12af_val", 32'(got_val), 32'h12AF);
        chk("f12af_bad", 32'(got_bad), 0);

        // blank and off-table patterns
        got_frame = 0;
        show(4'b0111, seg_tab[3], 8);
        show(4'b1011, 7'h7F, 8);
        show(4'b1101, seg_tab[5], 8);
        show(4'b1110, 7'h7E, 8);
        show(4'hF, 7'h7F, 3);
        chk("badpat_val", 32'(got_val), 32'h3050);
        chk("badpat_bad", 32'(got_bad), 32'h5);

        // too-short holds and a two-hot enable never capture
        got_frame = 0;
        for (int d = 3; d >= 0; d--) show(~(4'b0001 << d), seg_tab[d], 3);
        show(4'b1100, seg_tab[8], 8);
        show(4'hF, 7'h7F, 3);
        chk("short_noframe", 32'(got_frame), 0);

        // back-pressure: second frame dropped
        out_ready = 0;
        show_frame(16'h1234, 8);
        show_frame(16'h5678, 8);
        chk("ovr_value", 32'(out_value), 32'h1234);
        chk("ovr_flag", 32'(overrun), 1);
        out_ready = 1;
        tick();
        chk("ovr_drain", 32'(out_valid), 0);

        // accept and new completion on the same edge
        do_reset();
        out_ready = 0;
        show_frame(16'h1234, 8);
        rdy_mode = 2;
        show_frame(16'h5678, 8);
        rdy_mode = 0;
        chk("same_valid", 32'(out_valid), 1);
        chk("same_value", 32'(out_value), 32'h5678);
        chk("same_ovr", 32'(overrun), 0);
        out_ready = 1;
        tick();

        // reset mid-frame discards partial captures
        show(4'b0111, seg_tab[9], 8);
        show(4'b1011, seg_tab[8], 8);
        show(4'b1101, seg_tab[7], 8);
        do_reset();
        chk("midrst_value", 32'(out_value), 0);
        got_frame = 0;
        show(4'b1110, seg_tab[6], 10);
        chk("midrst_noframe", 32'(got_frame), 0);

        // randomized scanning; holds of exactly S+1 are avoided so that the
        // capture cycle never coincides with a digit change
        rdy_mode = 1;
        for (int n = 0; n < 120; n++) begin
            do begin
                if ($urandom % 10 == 0) an = 4'($urandom);
                else an = ~(4'b0001 << ($urandom % 4));
                if ($urandom % 6 == 0) seg = 7'($urandom);
                else seg = seg_tab[$urandom % 16];
            end while (an == an_in && seg == seg_in);
            hold = ($urandom % 3 == 0) ? int'($urandom_range(1, S)) : int'($urandom_range(S + 2, 10));
            show(an, seg, hold);
            if (n == 80) do_reset();
        end
        rdy_mode = 0;
        out_ready = 1;
        show(4'hF, 7'h7F, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical samples required before a digit is accepted; legal range is 1..255.
REQ-002 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 seg_in  input  7  segment lines, active-low; bit0=a, bit1=b, ..., bit6=g. Already synchronous to clk; the block SHALL NOT add synchronisers.
REQ-005 an_in  input  4  digit enables, active-low; bit0 is the least significant nibble.
REQ-006 out_value  output  16  decoded frame, digit3 in bits [15:12] down to digit0 in bits [3:0].
REQ-007 out_bad  output  4  per-digit flag, 1 = pattern not in the decode table (blank included).
REQ-008 out_valid  output  1  frame-available flag, handshaked with out_ready.
REQ-009 out_ready  input  1  consumer accepts the frame.
REQ-010 overrun  output  1  sticky flag: a completed frame was dropped.

Function
REQ-011 Decode table (seg_in hex -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
  - Any other pattern, including 7F (blank), SHALL decode to nibble 0 with its bad bit set.
REQ-012 A sample is qualifying only when an_in has exactly one bit low.
  - an_in = 1111, or two or more bits low, is non-qualifying.
REQ-013 Capture FSM states and transitions:
  - SETTLE: counts consecutive cycles in which an_in and seg_in equal their previous-cycle values and the sample is qualifying.
  - SETTLE: on any change or non-qualifying sample, the count SHALL return to 0.
  - SETTLE -> CAPTURE: when the count reaches STABLE_CYCLES.
  - CAPTURE: lasts exactly one cycle; decodes seg_in into the shadow nibble and shadow bad bit for the active digit, and sets that digit's seen bit.
  - CAPTURE -> HOLD: unconditional.
  - HOLD -> SETTLE: on any change of an_in or seg_in. A static display therefore captures each digit once.
REQ-014 A digit captured again before the frame completes SHALL overwrite its shadow nibble and bad bit (latest value wins).
REQ-015 Frame completion and transfer:
  - A frame is complete when all four seen bits are 1.
  - On the cycle after completion, if out_valid = 0, shadow nibbles and bad bits SHALL transfer to out_value and out_bad, out_valid SHALL go to 1, and all seen bits SHALL clear.
REQ-016 If a frame completes while out_valid = 1 and out_ready = 0:
  - the completed shadow frame SHALL be discarded and the seen bits cleared;
  - overrun SHALL set;
  - out_value and out_bad SHALL be unchanged.
REQ-017 out_valid SHALL clear on the cycle after out_valid = 1 and out_ready = 1.
  - If a frame completes in that same accepting cycle, the new frame SHALL load and out_valid SHALL remain 1, with no overrun.
REQ-018 out_value and out_bad SHALL be stable whenever out_valid = 1 and out_ready = 0.
REQ-019 overrun SHALL clear only on rst.
REQ-020 Minimum latency from a digit's first stable cycle to its seen bit is STABLE_CYCLES + 1 cycles. Frame transfer adds 1 cycle.

Reset
REQ-021 While rst = 1 at a rising edge, the following SHALL be 0 on the next cycle:
  - out_value, out_bad, out_valid, overrun;
  - all seen bits, shadow registers, the stability count, and the previous-sample registers;
  - the FSM SHALL be in SETTLE.
REQ-022 A reset mid-frame SHALL discard partial captures. Capture SHALL resume from SETTLE on the first cycle after rst falls.

Verification
REQ-023 Scan "12AF" (digit3..0 = 1,2,A,F), each digit held 8 cycles with STABLE_CYCLES = 4 and out_ready = 1 -> out_valid pulses with out_value = 0x12AF, out_bad = 0000.
REQ-024 Digit2 driven blank (7F) and digit0 driven 7E, others valid -> out_bad = 0101; nibbles 2 and 0 read 0.
REQ-025 Digit held only 3 cycles with STABLE_CYCLES = 4, or an_in = 1100 -> no capture for that digit; out_valid stays 0.
REQ-026 out_ready = 0, two full frames 0x1234 then 0x5678 -> out_value stays 0x1234, overrun = 1. Raising out_ready clears out_valid the next cycle.
REQ-027 Frame completes in the same cycle out_ready accepts 0x1234 -> out_valid stays 1, out_value = new frame, overrun = 0.
REQ-028 rst asserted after 3 digits are captured -> all outputs 0. The 4th digit alone does not produce a frame.
